// File: rtl/seg_scan_decoder.sv
// Receiver for the multiplexed 7-segment scan bus: resynchronises sel/time_led, decodes each
// settled digit and publishes a range-checked HH-MM-SS frame. Optional macro: SCAN_TIMEOUT_EN.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 150000
) (
    input  logic       CLK_50M,
    input  logic       reset,
    input  logic [7:0] time_led,
    input  logic [2:0] sel,
    output logic [3:0] hour_g,
    output logic [3:0] hour_d,
    output logic [3:0] minute_g,
    output logic [3:0] minute_d,
    output logic [3:0] second_g,
    output logic [3:0] second_d,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       link_lost
);

    localparam int unsigned STAB_W    = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned POS_W     = 3;
    localparam int unsigned CODE_W    = 4;
    localparam int unsigned NUM_SLOTS = 8;
    localparam logic [CODE_W-1:0] CODE_DASH    = CODE_W'(10);
    localparam logic [CODE_W-1:0] CODE_ILLEGAL = CODE_W'(15);

    typedef enum logic [1:0] {
        HUNT,
        SETTLE,
        WAIT_NEXT,
        CHECK
    } state_e;

    // Segment pattern (a..g, dp) to digit code; dash is 10, anything unrecognised is 15.
    function automatic logic [CODE_W-1:0] seg_decode(input logic [7:0] pat);
        logic [CODE_W-1:0] code;
        case (pat)
            8'hFC:   code = CODE_W'(0);
            8'h60:   code = CODE_W'(1);
            8'hDA:   code = CODE_W'(2);
            8'hF2:   code = CODE_W'(3);
            8'h66:   code = CODE_W'(4);
            8'hB6:   code = CODE_W'(5);
            8'hBE:   code = CODE_W'(6);
            8'hE0:   code = CODE_W'(7);
            8'hFE:   code = CODE_W'(8);
            8'hF6:   code = CODE_W'(9);
            8'h02:   code = CODE_DASH;
            default: code = CODE_ILLEGAL;
        endcase
        return code;
    endfunction

    logic [7:0]        led_s1_q, led_s1_d;
    logic [7:0]        led_s2_q, led_s2_d;
    logic [7:0]        led_prev_q, led_prev_d;
    logic [POS_W-1:0]  sel_s1_q, sel_s1_d;
    logic [POS_W-1:0]  sel_s2_q, sel_s2_d;
    logic [POS_W-1:0]  sel_prev_q, sel_prev_d;
    logic [STAB_W-1:0] stab_q, stab_d;

    state_e            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [CODE_W-1:0] slot_q [NUM_SLOTS];
    logic [CODE_W-1:0] slot_d [NUM_SLOTS];

    logic [CODE_W-1:0] hour_g_q, hour_g_d;
    logic [CODE_W-1:0] hour_d_q, hour_d_d;
    logic [CODE_W-1:0] minute_g_q, minute_g_d;
    logic [CODE_W-1:0] minute_d_q, minute_d_d;
    logic [CODE_W-1:0] second_g_q, second_g_d;
    logic [CODE_W-1:0] second_d_q, second_d_d;
    logic              frame_valid_q, frame_valid_d;
    logic              frame_err_q, frame_err_d;

    logic              sel_chg_c;
    logic              any_chg_c;
    logic              capture_c;
    logic [CODE_W-1:0] code_c;
    logic              legal_c;
    logic              timeout_c;

    // Synchronisers, change detection and settle counter
    always_comb begin
        led_s1_d   = time_led;
        led_s2_d   = led_s1_q;
        led_prev_d = led_s2_q;
        sel_s1_d   = sel;
        sel_s2_d   = sel_s1_q;
        sel_prev_d = sel_s2_q;

        sel_chg_c  = (sel_s2_q != sel_prev_q);
        any_chg_c  = sel_chg_c || (led_s2_q != led_prev_q);
        code_c     = seg_decode(led_s2_q);

        stab_d     = stab_q;
        capture_c  = 1'b0;
        if (any_chg_c) begin
            stab_d = '0;
        end else if (stab_q < STAB_W'(SETTLE_CYCLES)) begin
            stab_d = STAB_W'(stab_q + STAB_W'(1));
            // fires exactly once, on the cycle the counter saturates
            capture_c = (stab_q == STAB_W'(SETTLE_CYCLES - 1));
        end
    end

`ifdef SCAN_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              link_lost_q, link_lost_d;

    // Idle watchdog: counts cycles since the last synced sel change
    always_comb begin
        idle_d      = idle_q;
        link_lost_d = link_lost_q;
        timeout_c   = 1'b0;
        if (sel_chg_c) begin
            idle_d      = '0;
            link_lost_d = 1'b0;
        end else if (idle_q < IDLE_W'(TIMEOUT_CYCLES)) begin
            idle_d = IDLE_W'(idle_q + IDLE_W'(1));
            if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_c   = 1'b1;
                link_lost_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            idle_q      <= '0;
            link_lost_q <= 1'b0;
        end else begin
            idle_q      <= idle_d;
            link_lost_q <= link_lost_d;
        end
    end

    assign link_lost = link_lost_q;
`else
    assign timeout_c = 1'b0;
    assign link_lost = 1'b0;
`endif

    // Slot layout: 0/1 hour, 2 dash, 3/4 minute, 5 dash, 6/7 second
    always_comb begin
        legal_c = (slot_q[2] == CODE_DASH) && (slot_q[5] == CODE_DASH)
               && (slot_q[0] <= CODE_W'(2)) && (slot_q[1] <= CODE_W'(9))
               && (slot_q[3] <= CODE_W'(5)) && (slot_q[4] <= CODE_W'(9))
               && (slot_q[6] <= CODE_W'(5)) && (slot_q[7] <= CODE_W'(9))
               && !((slot_q[0] == CODE_W'(2)) && (slot_q[1] > CODE_W'(3)));
    end

    // Frame assembly FSM
    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        slot_d        = slot_q;
        hour_g_d      = hour_g_q;
        hour_d_d      = hour_d_q;
        minute_g_d    = minute_g_q;
        minute_d_d    = minute_d_q;
        second_g_d    = second_g_q;
        second_d_d    = second_d_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;

        if (timeout_c) begin
            state_d = HUNT;
        end else begin
            case (state_q)
                HUNT: begin
                    if (sel_chg_c && (sel_s2_q == '0)) begin
                        state_d = SETTLE;
                        pos_d   = '0;
                    end
                end
                SETTLE: begin
                    if (sel_chg_c) begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                    end else if (capture_c) begin
                        slot_d[pos_q] = code_c;
                        state_d = (pos_q == POS_W'(NUM_SLOTS - 1)) ? CHECK : WAIT_NEXT;
                    end
                end
                WAIT_NEXT: begin
                    if (sel_chg_c) begin
                        if (sel_s2_q == POS_W'(pos_q + POS_W'(1))) begin
                            pos_d   = POS_W'(pos_q + POS_W'(1));
                            state_d = SETTLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = HUNT;
                        end
                    end
                end
                CHECK: begin
                    state_d = HUNT;
                    if (legal_c) begin
                        hour_g_d      = slot_q[0];
                        hour_d_d      = slot_q[1];
                        minute_g_d    = slot_q[3];
                        minute_d_d    = slot_q[4];
                        second_g_d    = slot_q[6];
                        second_d_d    = slot_q[7];
                        frame_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            led_s1_q      <= '0;
            led_s2_q      <= '0;
            led_prev_q    <= '0;
            sel_s1_q      <= '0;
            sel_s2_q      <= '0;
            sel_prev_q    <= '0;
            stab_q        <= '0;
            state_q       <= HUNT;
            pos_q         <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
            hour_g_q      <= '0;
            hour_d_q      <= '0;
            minute_g_q    <= '0;
            minute_d_q    <= '0;
            second_g_q    <= '0;
            second_d_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            led_s1_q      <= led_s1_d;
            led_s2_q      <= led_s2_d;
            led_prev_q    <= led_prev_d;
            sel_s1_q      <= sel_s1_d;
            sel_s2_q      <= sel_s2_d;
            sel_prev_q    <= sel_prev_d;
            stab_q        <= stab_d;
            state_q       <= state_d;
            pos_q         <= pos_d;
            slot_q        <= slot_d;
            hour_g_q      <= hour_g_d;
            hour_d_q      <= hour_d_d;
            minute_g_q    <= minute_g_d;
            minute_d_q    <= minute_d_d;
            second_g_q    <= second_g_d;
            second_d_q    <= second_d_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign hour_g      = hour_g_q;
    assign hour_d      = hour_d_q;
    assign minute_g    = minute_g_q;
    assign minute_d    = minute_d_q;
    assign second_g    = second_g_q;
    assign second_d    = second_d_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans whole and faulty frames over the sel/time_led bus
// and checks published time and frame_valid/frame_err pulse counts.
module tb_seg_scan_decoder;

    localparam int unsigned SETTLE  = 16;
    localparam int unsigned TIMEOUT = 150000;
    localparam int          HOLD    = 1000;

    logic       clk;
    logic       reset;
    logic [7:0] time_led;
    logic [2:0] sel;
    logic [3:0] hour_g, hour_d, minute_g, minute_d, second_g, second_d;
    logic       frame_valid, frame_err, link_lost;

    int errors = 0;
    int checks = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int fv_base, fe_base;

    seg_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK_50M    (clk),
        .reset      (reset),
        .time_led   (time_led),
        .sel        (sel),
        .hour_g     (hour_g),
        .hour_d     (hour_d),
        .minute_g   (minute_g),
        .minute_d   (minute_d),
        .second_g   (second_g),
        .second_d   (second_d),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .link_lost  (link_lost)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Pulse tally, sampled away from the active edge
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if (frame_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input int hg, input int hd, input int mg,
                              input int md, input int sg, input int sd);
        check({tag, ".hour_g"},   32'(hour_g),   32'(hg));
        check({tag, ".hour_d"},   32'(hour_d),   32'(hd));
        check({tag, ".minute_g"}, 32'(minute_g), 32'(mg));
        check({tag, ".minute_d"}, 32'(minute_d), 32'(md));
        check({tag, ".second_g"}, 32'(second_g), 32'(sg));
        check({tag, ".second_d"}, 32'(second_d), 32'(sd));
    endtask

    // Present one (sel, pattern) pair for n cycles; drives change on the falling edge
    task automatic show(input logic [2:0] s, input logic [7:0] p, input int n);
        sel      = s;
        time_led = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_frame(input logic [63:0] pats, input int n);
        for (int i = 0; i < 8; i++) begin
            show(3'(i), pats[8*(7-i) +: 8], n);
        end
    endtask

    task automatic mark();
        fv_base = fv_cnt;
        fe_base = fe_cnt;
    endtask

    task automatic check_pulses(input string tag, input int fv, input int fe);
        check({tag, ".frame_valid_count"}, 32'(fv_cnt - fv_base), 32'(fv));
        check({tag, ".frame_err_count"},   32'(fe_cnt - fe_base), 32'(fe));
    endtask

    // Segment images: "12-34-56", "24-00-00", "09-59-48", "23-59-59"
    localparam logic [63:0] F_123456 = 64'h60DA02F2_6602B6BE;
    localparam logic [63:0] F_240000 = 64'hDA6602FC_FC02FCFC;
    localparam logic [63:0] F_095948 = 64'hFCF602B6_F60266FE;
    localparam logic [63:0] F_235959 = 64'hDAF202B6_F602B6F6;

    initial begin
        reset    = 1'b1;
        sel      = 3'd7;
        time_led = 8'h00;
        @(negedge clk);
        repeat (5) @(negedge clk);
        check_time("reset", 0, 0, 0, 0, 0, 0);
        check("reset.frame_valid", 32'(frame_valid), 32'd0);
        check("reset.frame_err",   32'(frame_err),   32'd0);
        check("reset.link_lost",   32'(link_lost),   32'd0);
        reset = 1'b0;
        show(3'd7, 8'h00, 50);

        // Clean 12-34-56 frame
        mark();
        scan_frame(F_123456, HOLD);
        check_pulses("good_frame", 1, 0);
        check_time("good_frame", 1, 2, 3, 4, 5, 6);

        // 24:00:00 is out of range: discarded, previous time held
        mark();
        scan_frame(F_240000, HOLD);
        check_pulses("hour24", 0, 1);
        check_time("hour24", 1, 2, 3, 4, 5, 6);

        // Skipped position 3: error shortly after sel reaches 4
        mark();
        for (int i = 0; i < 3; i++) show(3'(i), F_095948[8*(7-i) +: 8], HOLD);
        show(3'd4, 8'hF6, 10);
        check_pulses("skip_sel3", 0, 1);
        show(3'd4, 8'hF6, HOLD);
        for (int i = 5; i < 8; i++) show(3'(i), F_095948[8*(7-i) +: 8], HOLD);
        check_pulses("skip_sel3_tail", 0, 1);
        mark();
        scan_frame(F_095948, HOLD);
        check_pulses("after_skip", 1, 0);
        check_time("after_skip", 0, 9, 5, 9, 4, 8);

        // Position 1 held only SETTLE-2 cycles: missed, frame discarded
        mark();
        show(3'd0, 8'h60, HOLD);
        show(3'd1, 8'hDA, SETTLE - 2);
        for (int i = 2; i < 8; i++) show(3'(i), F_123456[8*(7-i) +: 8], HOLD);
        check_pulses("short_pos", 0, 1);
        check_time("short_pos", 0, 9, 5, 9, 4, 8);

        // Blank-segment glitches after and before capture are tolerated
        mark();
        for (int i = 0; i < 3; i++) show(3'(i), F_123456[8*(7-i) +: 8], HOLD);
        show(3'd3, 8'hF2, 500);
        show(3'd3, 8'h00, 3);
        show(3'd3, 8'hF2, 497);
        show(3'd4, 8'h66, 5);
        show(3'd4, 8'h00, 2);
        show(3'd4, 8'h66, HOLD);
        for (int i = 5; i < 8; i++) show(3'(i), F_123456[8*(7-i) +: 8], HOLD);
        check_pulses("glitch", 1, 0);
        check_time("glitch", 1, 2, 3, 4, 5, 6);

        // Reset in the middle of position 5
        mark();
        for (int i = 0; i < 5; i++) show(3'(i), F_235959[8*(7-i) +: 8], HOLD);
        show(3'd5, 8'h02, 100);
        reset = 1'b1;
        show(3'd5, 8'h02, 1);
        check_time("mid_reset", 0, 0, 0, 0, 0, 0);
        show(3'd5, 8'h02, 1);
        reset = 1'b0;
        show(3'd5, 8'h02, 100);
        show(3'd7, 8'hF6, 100);
        check_pulses("mid_reset", 0, 0);
        mark();
        scan_frame(F_235959, HOLD);
        check_pulses("after_reset", 1, 0);
        check_time("after_reset", 2, 3, 5, 9, 5, 9);

`ifdef SCAN_TIMEOUT_EN
        // Frozen scan raises link_lost around TIMEOUT cycles, next frame clears it
        mark();
        show(3'd7, 8'hF6, TIMEOUT - 1100);
        check("timeout.before", 32'(link_lost), 32'd0);
        show(3'd7, 8'hF6, 200);
        check("timeout.after", 32'(link_lost), 32'd1);
        scan_frame(F_123456, HOLD);
        check("timeout.resume", 32'(link_lost), 32'd0);
        check_pulses("timeout", 1, 0);
        check_time("timeout", 1, 2, 3, 4, 5, 6);
`else
        show(3'd7, 8'hF6, 2000);
        check("no_timeout.link_lost", 32'(link_lost), 32'd0);
`endif

        check("exclusive_pulses", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
